// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the RAM/IO port
// and the byte-serial memory arbiter.
interface mem_arbiter_if;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    modport slave (
        input  io_buffer_full, mem_din, flush,
               if_req, if_addr,
               lsb_req, lsb_wr, lsb_size,
               lsb_addr, lsb_wdata,
        output mem_dout, mem_a, mem_wr,
               if_done, if_data,
               lsb_done, lsb_rdata
    );

    modport master (
        output io_buffer_full, mem_din, flush,
               if_req, if_addr,
               lsb_req, lsb_wr, lsb_size,
               lsb_addr, lsb_wdata,
        input  mem_dout, mem_a, mem_wr,
               if_done, if_data,
               lsb_done, lsb_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the 8-bit RAM bus between instruction fetch and the
// load/store buffer, serialising 1/2/4-byte accesses.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IO_HI = 2'b11;

    typedef enum logic [2:0] {
        IDLE, IF_RD, LS_RD, LS_WR, TAIL
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic [1:0]  nm1;
    logic [1:0]  cm1;
    logic [1:0]  lsb_nm1;
    logic [1:0]  io_hold;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] asm_q;
    logic [31:0] last_word;
    logic        src_if;
    logic        io_st;
    logic        if_done;
    logic        lsb_done;
    logic [31:0] if_data;
    logic [31:0] lsb_rdata;
    logic        lsb_io;
    logic        lsb_ok;
    logic        if_ok;
    logic        grant_lsb;
    logic        grant_if;
    logic        last;
    logic        busy;

    always_comb begin
        lsb_nm1 = 2'd3;
        unique case (1'b1)
            bus.lsb_size == 2'b00: lsb_nm1 = 2'd0;
            bus.lsb_size == 2'b01: lsb_nm1 = 2'd1;
            default:               lsb_nm1 = 2'd3;
        endcase
    end

    assign lsb_io    = bus.lsb_addr[17:16] == IO_HI;
    assign cm1       = cnt - 2'd1;
    assign last      = cnt == nm1;
    assign last_word = asm_q
                     | ({24'd0, bus.mem_din} << {nm1, 3'b000});

    // io_hold covers the cycles io_buffer_full needs to reflect an
    // IO store that just completed.
    assign lsb_ok = bus.lsb_req && !lsb_done && !bus.flush
                 && io_hold == 2'b00
                 && !(bus.lsb_wr && lsb_io && bus.io_buffer_full);
    assign if_ok  = bus.if_req && !if_done && !bus.flush;

    always_comb begin
        state_nx  = state;
        grant_lsb = 1'b0;
        grant_if  = 1'b0;
        unique case (state)
            IDLE: begin
                if (lsb_ok) begin
                    grant_lsb = 1'b1;
                    state_nx  = bus.lsb_wr ? LS_WR : LS_RD;
                end else if (if_ok) begin
                    grant_if = 1'b1;
                    state_nx = IF_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (bus.flush)
                    state_nx = IDLE;
                else if (last)
                    state_nx = TAIL;
            end
            LS_WR:   if (last) state_nx = IDLE;
            TAIL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = state inside {IF_RD, LS_RD, LS_WR};

    assign bus.mem_a     = busy ? base + {30'd0, cnt} : 32'd0;
    assign bus.mem_wr    = state == LS_WR && rdy;
    assign bus.mem_dout  = state == LS_WR
                         ? wdata[{cnt, 3'b000} +: 8] : 8'd0;
    assign bus.if_done   = if_done;
    assign bus.if_data   = if_data;
    assign bus.lsb_done  = lsb_done;
    assign bus.lsb_rdata = lsb_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            nm1       <= 2'd0;
            io_hold   <= 2'd0;
            base      <= 32'd0;
            wdata     <= 32'd0;
            asm_q     <= 32'd0;
            src_if    <= 1'b0;
            io_st     <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= 32'd0;
            lsb_rdata <= 32'd0;
        end else if (rdy) begin
            state    <= state_nx;
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            io_hold  <= {1'b0, io_hold[1]};
            unique case (state)
                IDLE: begin
                    if (grant_lsb || grant_if) begin
                        base   <= grant_lsb ? bus.lsb_addr
                                            : bus.if_addr;
                        nm1    <= grant_lsb ? lsb_nm1 : 2'd3;
                        wdata  <= bus.lsb_wdata;
                        src_if <= grant_if;
                        io_st  <= grant_lsb && bus.lsb_wr
                               && lsb_io;
                        cnt    <= 2'd0;
                        asm_q  <= 32'd0;
                    end
                end
                IF_RD, LS_RD: begin
                    if (cnt != 2'd0)
                        asm_q[{cm1, 3'b000} +: 8] <= bus.mem_din;
                    cnt <= cnt + 2'd1;
                end
                LS_WR: begin
                    cnt <= cnt + 2'd1;
                    if (last) begin
                        lsb_done <= 1'b1;
                        if (io_st)
                            io_hold <= 2'b11;
                    end
                end
                TAIL: begin
                    if (!bus.flush) begin
                        if (src_if) begin
                            if_done <= 1'b1;
                            if_data <= last_word;
                        end else begin
                            lsb_done  <= 1'b1;
                            lsb_rdata <= last_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a byte-array
// RAM model and a reference memory image.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    logic rdy;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int         io_wr_n = 0;
    logic [7:0] io_last = 8'd0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Paused RAM: read data and writes only advance while rdy is high.
    always @(posedge clk) begin
        if (rdy) begin
            bus.mem_din <= ram[bus.mem_a[15:0]];
            if (bus.mem_wr) begin
                if (bus.mem_a[17:16] == 2'b11) begin
                    io_wr_n = io_wr_n + 1;
                    io_last = bus.mem_dout;
                end else begin
                    ram[bus.mem_a[15:0]] = bus.mem_dout;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_n(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a,
                                             input int n);
        logic [31:0] r;
        logic [15:0] idx;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            idx = a[15:0] + 16'(i);
            r[8*i +: 8] = ref_mem[idx];
        end
        return r;
    endfunction

    task automatic put(input logic [15:0] a, input logic [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic quiet();
        bus.if_req = 1'b0;
        bus.lsb_req = 1'b0;
        bus.flush = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.lsb_wr = 1'b0;
        bus.lsb_size = 2'b00;
        bus.if_addr = 32'd0;
        bus.lsb_addr = 32'd0;
        bus.lsb_wdata = 32'd0;
    endtask

    // Runs one transaction with random rdy stalls; reports the cycle
    // of the done pulse counted from the request cycle.
    task automatic xact(input bit is_if, input bit wr,
                        input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int pct,
                        output int lat, output int stalls,
                        output logic [31:0] rd);
        int t;
        lat = -1;
        stalls = 0;
        rd = 32'd0;
        if (is_if) begin
            bus.if_addr = a;
            bus.if_req = 1'b1;
        end else begin
            bus.lsb_wr = wr;
            bus.lsb_size = sz;
            bus.lsb_addr = a;
            bus.lsb_wdata = wd;
            bus.lsb_req = 1'b1;
        end
        rdy = $urandom_range(99) >= pct;
        if (!rdy) stalls++;
        t = 0;
        while (lat < 0 && t < 80) begin
            tick();
            t++;
            if (is_if ? bus.if_done : bus.lsb_done) begin
                lat = t;
                rd = is_if ? bus.if_data : bus.lsb_rdata;
                rdy = 1'b1;
                bus.if_req = 1'b0;
                bus.lsb_req = 1'b0;
            end else begin
                rdy = $urandom_range(99) >= pct;
                if (!rdy) stalls++;
            end
        end
        rdy = 1'b1;
        bus.if_req = 1'b0;
        bus.lsb_req = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1;
        rdy = 1'b1;
        quiet();
        tick();
        tick();
        n_checks += 7;
        if (bus.mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mem_a got %h want 0", bus.mem_a);
        end
        if (bus.mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mem_wr got %b want 0", bus.mem_wr);
        end
        if (bus.mem_dout !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mem_dout got %h want 0", bus.mem_dout);
        end
        if (bus.if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_if_done got %b want 0", bus.if_done);
        end
        if (bus.lsb_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lsb_done got %b want 0", bus.lsb_done);
        end
        if (bus.if_data !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_if_data got %h want 0", bus.if_data);
        end
        if (bus.lsb_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_lsb_rdata got %h want 0", bus.lsb_rdata);
        end
        rst = 1'b0;
        tick();
        bus.if_addr = 32'h100;
        bus.if_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.mem_a !== 32'h101) begin
            n_fail++;
            $display("FAIL rst_mid_addr got %h want 101", bus.mem_a);
        end
        rst = 1'b1;
        bus.if_req = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_abort got %h want 0", bus.mem_a);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.if_done) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_done got %b want 0", seen);
        end
    endtask

    task automatic test_if_fetch();
        logic [31:0] ea;
        put(16'h100, 8'h13);
        put(16'h101, 8'h05);
        put(16'h102, 8'h00);
        put(16'h103, 8'h00);
        bus.if_addr = 32'h100;
        bus.if_req = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t <= 4) begin
                ea = 32'h100 + 32'(t - 1);
                n_checks++;
                if (bus.mem_a !== ea || bus.mem_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL if_addr t%0d got %h/%b want %h/0",
                             t, bus.mem_a, bus.mem_wr, ea);
                end
            end
            n_checks++;
            if (bus.if_done !== (t == 6)) begin
                n_fail++;
                $display("FAIL if_done t%0d got %b want %b",
                         t, bus.if_done, t == 6);
            end
            if (t == 6) begin
                ea = ref_read(32'h100, 4);
                n_checks++;
                if (bus.if_data !== ea) begin
                    n_fail++;
                    $display("FAIL if_data got %h want %h",
                             bus.if_data, ea);
                end
                bus.if_req = 1'b0;
            end
        end
        n_checks++;
        if (bus.mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL if_idle_addr got %h want 0", bus.mem_a);
        end
    endtask

    task automatic test_priority();
        logic [31:0] ea;
        put(16'h20, 8'hFF);
        bus.if_addr = 32'h200;
        bus.if_req = 1'b1;
        bus.lsb_wr = 1'b0;
        bus.lsb_size = 2'b00;
        bus.lsb_addr = 32'h20;
        bus.lsb_req = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            n_checks += 2;
            if (bus.lsb_done !== (t == 3)) begin
                n_fail++;
                $display("FAIL prio_lsb_done t%0d got %b",
                         t, bus.lsb_done);
            end
            if (bus.if_done !== (t == 9)) begin
                n_fail++;
                $display("FAIL prio_if_done t%0d got %b",
                         t, bus.if_done);
            end
            if (t == 1 || (t >= 4 && t <= 7)) begin
                ea = (t == 1) ? 32'h20 : 32'h200 + 32'(t - 4);
                n_checks++;
                if (bus.mem_a !== ea) begin
                    n_fail++;
                    $display("FAIL prio_addr t%0d got %h want %h",
                             t, bus.mem_a, ea);
                end
            end
            if (t == 3) begin
                ea = ref_read(32'h20, 1);
                n_checks++;
                if (bus.lsb_rdata !== ea) begin
                    n_fail++;
                    $display("FAIL prio_lsb_rdata got %h want %h",
                             bus.lsb_rdata, ea);
                end
                bus.lsb_req = 1'b0;
            end
            if (t == 9) begin
                ea = ref_read(32'h200, 4);
                n_checks++;
                if (bus.if_data !== ea) begin
                    n_fail++;
                    $display("FAIL prio_if_data got %h want %h",
                             bus.if_data, ea);
                end
                bus.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_store_half();
        logic [31:0] wd;
        logic [31:0] ea;
        logic [7:0]  eb;
        wd = 32'hDEADBEEF;
        bus.lsb_wr = 1'b1;
        bus.lsb_size = 2'b01;
        bus.lsb_addr = 32'h40;
        bus.lsb_wdata = wd;
        bus.lsb_req = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            n_checks++;
            if (t <= 2) begin
                ea = 32'h40 + 32'(t - 1);
                eb = wd[8*(t-1) +: 8];
                if (bus.mem_wr !== 1'b1 || bus.mem_a !== ea
                    || bus.mem_dout !== eb) begin
                    n_fail++;
                    $display("FAIL st_bus t%0d got %b %h %h want 1 %h %h",
                             t, bus.mem_wr, bus.mem_a, bus.mem_dout,
                             ea, eb);
                end
            end else if (bus.mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL st_wr_end t%0d got %b want 0",
                         t, bus.mem_wr);
            end
            n_checks++;
            if (bus.lsb_done !== (t == 3)) begin
                n_fail++;
                $display("FAIL st_done t%0d got %b", t, bus.lsb_done);
            end
            if (t == 3) bus.lsb_req = 1'b0;
        end
        ref_mem[16'h40] = wd[7:0];
        ref_mem[16'h41] = wd[15:8];
        for (int i = 16'h40; i <= 16'h42; i++) begin
            n_checks++;
            if (ram[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL st_ram[%h] got %h want %h",
                         i, ram[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_io_store();
        int n0;
        int wr_cyc;
        int done_cyc;
        logic [31:0] ea;
        n0 = io_wr_n;
        wr_cyc = -1;
        done_cyc = -1;
        bus.io_buffer_full = 1'b1;
        bus.lsb_wr = 1'b1;
        bus.lsb_size = 2'b00;
        bus.lsb_addr = 32'h30000;
        bus.lsb_wdata = 32'h1234565A;
        bus.lsb_req = 1'b1;
        for (int t = 1; t <= 12 && done_cyc < 0; t++) begin
            tick();
            if (t == 3) bus.io_buffer_full = 1'b0;
            if (bus.mem_wr && wr_cyc < 0) wr_cyc = t;
            if (bus.lsb_done) begin
                done_cyc = t;
                bus.lsb_req = 1'b0;
            end
        end
        // Full in T0..T2, so grant in T3, write T4, done T5.
        n_checks += 4;
        if (wr_cyc !== 4) begin
            n_fail++;
            $display("FAIL io_wr_cycle got %0d want 4", wr_cyc);
        end
        if (done_cyc !== 5) begin
            n_fail++;
            $display("FAIL io_done_cycle got %0d want 5", done_cyc);
        end
        if (io_wr_n - n0 !== 1) begin
            n_fail++;
            $display("FAIL io_wr_count got %0d want 1", io_wr_n - n0);
        end
        if (io_last !== 8'h5A) begin
            n_fail++;
            $display("FAIL io_wr_data got %h want 5a", io_last);
        end
        tick();
        bus.lsb_wr = 1'b0;
        bus.lsb_addr = 32'h80;
        bus.lsb_req = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL io_gap got %h want 0", bus.mem_a);
        end
        tick();
        n_checks++;
        if (bus.mem_a !== 32'h80) begin
            n_fail++;
            $display("FAIL io_next_addr got %h want 80", bus.mem_a);
        end
        tick();
        tick();
        ea = ref_read(32'h80, 1);
        n_checks++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== ea) begin
            n_fail++;
            $display("FAIL io_next_load got %b %h want 1 %h",
                     bus.lsb_done, bus.lsb_rdata, ea);
        end
        bus.lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        bit seen;
        logic [31:0] ea;
        bus.if_addr = 32'h300;
        bus.if_req = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.mem_a !== 32'h302) begin
            n_fail++;
            $display("FAIL fl_pre got %h want 302", bus.mem_a);
        end
        bus.flush = 1'b1;
        bus.if_addr = 32'h400;
        seen = 1'b0;
        tick();
        bus.flush = 1'b0;
        if (bus.if_done) seen = 1'b1;
        n_checks++;
        if (bus.mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL fl_abort got %h want 0", bus.mem_a);
        end
        for (int t = 5; t <= 10; t++) begin
            tick();
            if (t == 5) begin
                n_checks++;
                if (bus.mem_a !== 32'h400) begin
                    n_fail++;
                    $display("FAIL fl_regrant got %h want 400",
                             bus.mem_a);
                end
            end
            if (t < 10 && bus.if_done) seen = 1'b1;
            if (t == 10) begin
                ea = ref_read(32'h400, 4);
                n_checks++;
                if (bus.if_done !== 1'b1 || bus.if_data !== ea) begin
                    n_fail++;
                    $display("FAIL fl_new_done got %b %h want 1 %h",
                             bus.if_done, bus.if_data, ea);
                end
                bus.if_req = 1'b0;
            end
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_no_done got %b want 0", seen);
        end
        tick();
        bus.flush = 1'b1;
        bus.lsb_wr = 1'b0;
        bus.lsb_size = 2'b10;
        bus.lsb_addr = 32'h500;
        bus.lsb_req = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL fl_mask got %h want 0", bus.mem_a);
        end
        tick();
        n_checks++;
        if (bus.mem_a !== 32'h500) begin
            n_fail++;
            $display("FAIL fl_after got %h want 500", bus.mem_a);
        end
        repeat (5) tick();
        ea = ref_read(32'h500, 4);
        n_checks++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== ea) begin
            n_fail++;
            $display("FAIL fl_load got %b %h want 1 %h",
                     bus.lsb_done, bus.lsb_rdata, ea);
        end
        bus.lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_rdy();
        logic [31:0] ea;
        bus.if_addr = 32'h600;
        bus.if_req = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        tick();
        #1;
        n_checks++;
        if (bus.mem_a !== 32'h601 || bus.mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_hold got %h %b want 601 0",
                     bus.mem_a, bus.mem_wr);
        end
        tick();
        rdy = 1'b1;
        n_checks++;
        if (bus.mem_a !== 32'h601) begin
            n_fail++;
            $display("FAIL rdy_hold2 got %h want 601", bus.mem_a);
        end
        for (int t = 5; t <= 8; t++) begin
            tick();
            n_checks++;
            if (bus.if_done !== (t == 8)) begin
                n_fail++;
                $display("FAIL rdy_done t%0d got %b", t, bus.if_done);
            end
            if (t == 8) begin
                ea = ref_read(32'h600, 4);
                n_checks++;
                if (bus.if_data !== ea) begin
                    n_fail++;
                    $display("FAIL rdy_data got %h want %h",
                             bus.if_data, ea);
                end
                bus.if_req = 1'b0;
            end
        end
        tick();
        bus.lsb_wr = 1'b1;
        bus.lsb_size = 2'b00;
        bus.lsb_addr = 32'h700;
        bus.lsb_wdata = 32'h00000077;
        bus.lsb_req = 1'b1;
        tick();
        rdy = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h700) begin
            n_fail++;
            $display("FAIL rdy_wr_gate got %b %h want 0 700",
                     bus.mem_wr, bus.mem_a);
        end
        tick();
        rdy = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h77) begin
            n_fail++;
            $display("FAIL rdy_wr_go got %b %h want 1 77",
                     bus.mem_wr, bus.mem_dout);
        end
        tick();
        n_checks++;
        if (bus.lsb_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rdy_wr_done got %b want 1", bus.lsb_done);
        end
        bus.lsb_req = 1'b0;
        ref_mem[16'h700] = 8'h77;
        tick();
        n_checks++;
        if (ram[16'h700] !== ref_mem[16'h700]) begin
            n_fail++;
            $display("FAIL rdy_wr_ram got %h want 77", ram[16'h700]);
        end
    endtask

    task automatic test_random();
        int          kind;
        int          n;
        int          lat;
        int          stalls;
        int          exp_lat;
        int          bad;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] ea;
        logic [15:0] idx;
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(2);
            sz = 2'($urandom_range(3));
            a = 32'($urandom_range(16'h0FFF));
            wd = $urandom;
            n = (kind == 0) ? 4 : size_n(sz);
            xact(kind == 0, kind == 2, sz, a, wd, 25,
                 lat, stalls, rd);
            exp_lat = ((kind == 2) ? n + 1 : n + 2) + stalls;
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rnd_lat #%0d kind %0d got %0d want %0d",
                         k, kind, lat, exp_lat);
            end
            if (kind == 2) begin
                for (int i = 0; i < n; i++) begin
                    idx = a[15:0] + 16'(i);
                    ref_mem[idx] = wd[8*i +: 8];
                end
            end else begin
                ea = ref_read(a, n);
                n_checks++;
                if (rd !== ea) begin
                    n_fail++;
                    $display("FAIL rnd_data #%0d addr %h got %h want %h",
                             k, a, rd, ea);
                end
            end
            tick();
        end
        bad = 0;
        for (int i = 0; i < 16'h1004; i++)
            if (ram[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rnd_ram_image got %0d bad bytes want 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        quiet();
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_if_fetch();
        test_priority();
        test_store_half();
        test_io_store();
        test_flush();
        test_rdy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial RAM port controller that shares the single 8-bit memory bus between instruction fetch (IF) and the load/store buffer (LSB). It sits between the CPU core and the top-level RAM/IO port and serialises 1/2/4-byte transactions into per-cycle byte accesses. It returns assembled little-endian words with a one-cycle done pulse, and holds IO stores off while the IO buffer is full.

## Interface
- IO_HI, 2'b11: an address is IO when addr[17:16] == IO_HI.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- io_buffer_full  in  1  IO write buffer full.
- mem_din  in  8  RAM read data for the address presented in the previous cycle.
- mem_dout  out  8  RAM write data.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  write strobe; 1 = write, 0 = read.
- flush  in  1  misprediction flush.
- if_req  in  1  IF fetch request; always a 4-byte read.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched instruction.
- lsb_req  in  1  LSB request.
- lsb_wr  in  1  1 = store, 0 = load.
- lsb_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- lsb_addr  in  32  byte address.
- lsb_wdata  in  32  store data; the low n bytes are used.
- lsb_done  out  1  one-cycle pulse; lsb_rdata valid for loads.
- lsb_rdata  out  32  load data, zero-extended (the LSB sign-extends).

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR, TAIL. A 2-bit byte counter cnt and a 32-bit assembly register are used.
- Byte count n is 4 for IF, and 1/2/4 for LSB per lsb_size.
- Arbitration in IDLE uses fixed priority: LSB over IF.
  - An LSB store to an IO address with io_buffer_full = 1 is not granted; IF may be granted instead in that cycle.
- Grant behaviour:
  - Latch the address, n, and wdata.
  - cnt := 0.
  - Go to IF_RD, LS_RD or LS_WR.
- Read state, each cycle:
  - mem_a = base + cnt, mem_wr = 0.
  - Byte cnt-1 is captured from mem_din into bits [8(cnt-1)+7 : 8(cnt-1)].
  - After n addresses have been issued, go to TAIL to capture the last byte.
- Write state, each cycle:
  - mem_a = base + cnt, mem_wr = 1, mem_dout = wdata byte cnt.
  - After n bytes, go to IDLE.
- Done pulse: completion raises if_done or lsb_done for exactly one cycle. if_data and lsb_rdata hold their value until the next done.
- IO rule: after any IO store, one forced IDLE cycle occurs with no grant to LSB, because io_buffer_full lags by one cycle.
- Requester contract:
  - req, addr, size and wdata stay stable until done.
  - The requester's req is masked in the cycle its done is high, so no re-grant occurs.
- flush:
  - Aborts IF_RD and LS_RD: next state is IDLE, no done is raised, and partial data is discarded.
  - Masks if_req and lsb_req for grant in the flush cycle.
  - LS_WR is never aborted, because stores are committed.
- rdy = 0: all registers hold, and mem_wr is gated to 0 combinationally. The top level pauses the RAM, so mem_din holds.
- Reset: state IDLE, cnt 0, mem_a 0, mem_wr 0, mem_dout 0, if_done 0, lsb_done 0, if_data 0, lsb_rdata 0. Reset mid-transaction is silently dropped.
- Idle outputs: mem_a = 0, mem_wr = 0.

## Timing
- Read, request sampled in T0 (IDLE):
  - Addresses are issued in T1..Tn.
  - Data arrives on mem_din in T2..T(n+1).
  - done is high in T(n+2). A word read therefore completes in T6.
  - The next grant can be sampled in T(n+2).
- Write, request sampled in T0:
  - mem_wr = 1 in T1..Tn.
  - done is high in T(n+1).
- Back-to-back: done cycle = IDLE cycle, so no bus bubble beyond TAIL.
- Each rdy = 0 cycle extends all of the above latencies by one cycle.

## Test plan
- IF word fetch, if_addr = 0x100, RAM bytes 13 05 00 00:
  - mem_a = 0x100..0x103 in T1..T4.
  - if_done in T6, if_data = 0x00000513.
- if_req and lsb_req (load byte at 0x20, RAM value 0xFF) both high in T0:
  - LSB is served first; lsb_done in T3 with lsb_rdata = 0x000000FF.
  - IF is granted in T3; if_done in T9.
- Store half, addr 0x40, wdata 0xDEADBEEF:
  - mem_wr = 1 with (0x40, EF) in T1 and (0x41, BE) in T2.
  - lsb_done in T3.
- IO store byte to 0x30000 with io_buffer_full = 1 for 3 cycles:
  - No mem_wr until full drops.
  - Then exactly one write of wdata[7:0].
  - The following LSB request waits one extra cycle.
- flush in T3 of an IF fetch:
  - No if_done.
  - mem_a = 0 from T4.
  - A new if_req is granted from T4.
- rdy = 0 during T2–T3 of a word read:
  - Outputs hold and mem_wr = 0.
  - if_done in T8 with correct data.
